// File: rtl/wb_shared_bus.sv
// Wishbone B4 shared bus: round-robin arbitration among M masters, base/mask
// decode onto S slaves, combinational response routing and a stalled-strobe watchdog.
module wb_shared_bus #(
  parameter int M = 4,
  parameter int S = 4,
  parameter int Dw = 32,
  parameter int Aw = 32,
  parameter int SELw = 4,
  parameter int TAGw = 3,
  parameter logic [S*Aw-1:0] ADDR_BASE = '0,
  parameter logic [S*Aw-1:0] ADDR_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [M*Aw-1:0]   m_adr_i,
  input  logic [M*Dw-1:0]   m_dat_i,
  input  logic [M*SELw-1:0] m_sel_i,
  input  logic [M*TAGw-1:0] m_tag_i,
  input  logic [M-1:0]      m_we_i,
  input  logic [M-1:0]      m_stb_i,
  input  logic [M-1:0]      m_cyc_i,
  output logic [Dw-1:0]     m_dat_o,
  output logic [M-1:0]      m_ack_o,
  output logic [M-1:0]      m_err_o,
  output logic [M-1:0]      m_rty_o,
  output logic [M-1:0]      m_grant_o,
  output logic [Aw-1:0]     s_adr_o,
  output logic [Dw-1:0]     s_dat_o,
  output logic [SELw-1:0]   s_sel_o,
  output logic [TAGw-1:0]   s_tag_o,
  output logic              s_we_o,
  output logic [S-1:0]      s_cyc_o,
  output logic [S-1:0]      s_stb_o,
  input  logic [S*Dw-1:0]   s_dat_i,
  input  logic [S-1:0]      s_ack_i,
  input  logic [S-1:0]      s_err_i,
  input  logic [S-1:0]      s_rty_i
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [M-1:0]  grant, grant_nxt;
  logic [PW-1:0] ptr, ptr_nxt, gidx, pick;
  logic          pick_vld;
  logic [CW-1:0] cnt;
  logic          dec_err;
  logic          cyc_g, stb_g, hit_any, to_fire, ack, err, rty, resp;
  logic [S-1:0]  sel;

  // Round-robin search begins one past the previous owner.
  always_comb begin
    pick = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= M; k++) begin
      if (!pick_vld && m_cyc_i[(int'(ptr) + k) % M]) begin
        pick_vld = 1'b1;
        pick = PW'((int'(ptr) + k) % M);
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < M; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt = ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = OWNED;
          grant_nxt = '0;
          grant_nxt[pick] = 1'b1;
        end
      end
      default: begin
        if (!m_cyc_i[gidx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt = gidx;
        end
      end
    endcase
  end

  // With no owner gidx is 0, so master 0 drives the shared lines.
  assign s_adr_o = m_adr_i[int'(gidx)*Aw +: Aw];
  assign s_dat_o = m_dat_i[int'(gidx)*Dw +: Dw];
  assign s_sel_o = m_sel_i[int'(gidx)*SELw +: SELw];
  assign s_tag_o = m_tag_i[int'(gidx)*TAGw +: TAGw];
  assign s_we_o  = m_we_i[gidx];
  assign cyc_g   = |(grant & m_cyc_i);
  assign stb_g   = |(grant & m_stb_i);

  always_comb begin
    sel = '0;
    hit_any = 1'b0;
    for (int i = 0; i < S; i++) begin
      if (!hit_any && ((s_adr_o & ADDR_MASK[i*Aw +: Aw]) == ADDR_BASE[i*Aw +: Aw])) begin
        sel[i] = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  assign to_fire = (TIMEOUT > 0) ? (stb_g && (cnt == TO_LAST)) : 1'b0;
  assign s_cyc_o = sel & {S{cyc_g}};
  assign s_stb_o = sel & {S{stb_g & ~to_fire}};

  assign ack  = |(sel & s_ack_i);
  assign err  = |(sel & s_err_i);
  assign rty  = |(sel & s_rty_i);
  assign resp = ack | err | rty | dec_err;

  assign m_grant_o = grant;
  assign m_ack_o   = grant & {M{ack}};
  assign m_err_o   = grant & {M{err | dec_err | to_fire}};
  assign m_rty_o   = grant & {M{rty}};

  always_comb begin
    m_dat_o = '0;
    for (int i = 0; i < S; i++) begin
      if (sel[i]) m_dat_o = s_dat_i[i*Dw +: Dw];
    end
  end

  // Decode-miss err alternates while stb is held so each strobe sees one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= PW'(M - 1);
      cnt     <= '0;
      dec_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      dec_err <= stb_g & cyc_g & ~hit_any & ~dec_err;
      if (!stb_g || resp || to_fire || (grant_nxt != grant) || (TIMEOUT == 0))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: directed scenarios plus a randomized phase, all
// outputs compared against a cycle-level behavioural model of the bus.
module tb_wb_shared_bus;
  localparam int M = 4, S = 4, Dw = 32, Aw = 32, SELw = 4, TAGw = 3, TO = 8;
  localparam logic [S*Aw-1:0] BASE_F = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [S*Aw-1:0] MASK_F = {32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic clk, reset;
  logic [M*Aw-1:0] m_adr_i;
  logic [M*Dw-1:0] m_dat_i;
  logic [M*SELw-1:0] m_sel_i;
  logic [M*TAGw-1:0] m_tag_i;
  logic [M-1:0] m_we_i, m_stb_i, m_cyc_i;
  logic [Dw-1:0] m_dat_o;
  logic [M-1:0] m_ack_o, m_err_o, m_rty_o, m_grant_o;
  logic [Aw-1:0] s_adr_o;
  logic [Dw-1:0] s_dat_o;
  logic [SELw-1:0] s_sel_o;
  logic [TAGw-1:0] s_tag_o;
  logic s_we_o;
  logic [S-1:0] s_cyc_o, s_stb_o;
  logic [S*Dw-1:0] s_dat_i;
  logic [S-1:0] s_ack_i, s_err_i, s_rty_i;

  wb_shared_bus #(.M(M), .S(S), .Dw(Dw), .Aw(Aw), .SELw(SELw), .TAGw(TAGw),
    .ADDR_BASE(BASE_F), .ADDR_MASK(MASK_F), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_tag_i(m_tag_i),
    .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_grant_o(m_grant_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_tag_o(s_tag_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total, bad;

  logic [Aw-1:0] adr [M];
  logic [Dw-1:0] dat [M];
  logic [SELw-1:0] sel [M];
  logic [TAGw-1:0] tag [M];
  logic we [M], stb [M], cyc [M];
  logic [Dw-1:0] sdat [S];
  logic sack [S], serr [S], srty [S];

  // Model: current owner (-1 = none), last owner, consecutive unanswered strobe cycles,
  // and whether a decode-miss err is due this cycle.
  int mown, mlast, mwait;
  bit mdec;
  int e_h;
  logic [Aw-1:0] e_a;
  bit e_stbg, e_cycg, e_fire, e_ack, e_err, e_rty;

  task automatic chk(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag_s, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < M; i++) begin
      m_adr_i[i*Aw +: Aw] = adr[i];
      m_dat_i[i*Dw +: Dw] = dat[i];
      m_sel_i[i*SELw +: SELw] = sel[i];
      m_tag_i[i*TAGw +: TAGw] = tag[i];
      m_we_i[i] = we[i];
      m_stb_i[i] = stb[i];
      m_cyc_i[i] = cyc[i];
    end
    for (int j = 0; j < S; j++) begin
      s_dat_i[j*Dw +: Dw] = sdat[j];
      s_ack_i[j] = sack[j];
      s_err_i[j] = serr[j];
      s_rty_i[j] = srty[j];
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < M; i++) begin
      adr[i] = '0; dat[i] = '0; sel[i] = '0; tag[i] = '0;
      we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0;
    end
    for (int j = 0; j < S; j++) begin
      sdat[j] = '0; sack[j] = 1'b0; serr[j] = 1'b0; srty[j] = 1'b0;
    end
  endtask

  function automatic int dec(input logic [Aw-1:0] a);
    for (int i = 0; i < S; i++)
      if ((a & MASK_F[i*Aw +: Aw]) == BASE_F[i*Aw +: Aw]) return i;
    return -1;
  endfunction

  function automatic void eval_model();
    e_stbg = 1'b0; e_cycg = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0;
    e_a = adr[0];
    if (mown >= 0) begin
      e_a = adr[mown];
      e_stbg = stb[mown];
      e_cycg = cyc[mown];
    end
    e_h = dec(e_a);
    e_fire = e_stbg && (mwait == TO - 1);
    if (e_h >= 0) begin
      e_ack = sack[e_h]; e_err = serr[e_h]; e_rty = srty[e_h];
    end
  endfunction

  task automatic model_reset();
    mown = -1; mlast = M - 1; mwait = 0; mdec = 1'b0;
  endtask

  task automatic check_outputs(input string t);
    logic [63:0] g, sd, slv;
    int o;
    eval_model();
    o = (mown < 0) ? 0 : mown;
    g = (mown < 0) ? 64'd0 : (64'd1 << mown);
    sd = 64'd0;
    slv = 64'd0;
    if (e_h >= 0) begin
      sd = 64'(sdat[e_h]);
      slv = 64'd1 << e_h;
    end
    chk({t, ".grant"}, 64'(m_grant_o), g);
    chk({t, ".s_adr"}, 64'(s_adr_o), 64'(e_a));
    chk({t, ".s_dat"}, 64'(s_dat_o), 64'(dat[o]));
    chk({t, ".s_sel"}, 64'(s_sel_o), 64'(sel[o]));
    chk({t, ".s_tag"}, 64'(s_tag_o), 64'(tag[o]));
    chk({t, ".s_we"}, 64'(s_we_o), 64'(we[o]));
    chk({t, ".s_cyc"}, 64'(s_cyc_o), e_cycg ? slv : 64'd0);
    chk({t, ".s_stb"}, 64'(s_stb_o), (e_stbg && !e_fire) ? slv : 64'd0);
    chk({t, ".m_ack"}, 64'(m_ack_o), e_ack ? g : 64'd0);
    chk({t, ".m_err"}, 64'(m_err_o), (e_err || mdec || e_fire) ? g : 64'd0);
    chk({t, ".m_rty"}, 64'(m_rty_o), e_rty ? g : 64'd0);
    chk({t, ".m_dat"}, 64'(m_dat_o), sd);
  endtask

  task automatic tick();
    int nown, nlast;
    bit nd, resp;
    eval_model();
    nd = e_stbg && e_cycg && (e_h < 0) && !mdec;
    resp = e_ack || e_err || e_rty || mdec;
    nown = mown;
    nlast = mlast;
    if (mown < 0) begin
      for (int k = 1; k <= M; k++)
        if (nown < 0 && cyc[(mlast + k) % M]) nown = (mlast + k) % M;
    end else if (!cyc[mown]) begin
      nlast = mown;
      nown = -1;
    end
    if (!e_stbg || resp || e_fire || nown != mown) mwait = 0;
    else mwait++;
    mdec = nd; mown = nown; mlast = nlast;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst.grant", 64'(m_grant_o), 64'd0);
    chk("rst.s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst.s_stb", 64'(s_stb_o), 64'd0);
    chk("rst.m_ack", 64'(m_ack_o), 64'd0);
    chk("rst.m_err", 64'(m_err_o), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int start [3];
    int prev;
    logic [3:0] nib;
    total = 0; bad = 0;
    clear_all();
    apply();
    reset = 1'b0;
    model_reset();
    #2;
    chk("init.grant", 64'(m_grant_o), 64'd0);
    chk("init.s_cyc", 64'(s_cyc_o), 64'd0);
    chk("init.s_stb", 64'(s_stb_o), 64'd0);
    chk("init.m_ack", 64'(m_ack_o), 64'd0);
    chk("init.m_err", 64'(m_err_o), 64'd0);
    chk("init.m_rty", 64'(m_rty_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single write from master 0 to slave 1.
    adr[0] = 32'h1000_0004; dat[0] = 32'hCAFE_F00D; sel[0] = 4'hF; tag[0] = 3'd5;
    we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    apply(); #1;
    check_outputs("t1.req");
    chk("t1.arb_lat", 64'(m_grant_o), 64'd0);
    tick();
    sack[1] = 1'b1; sdat[1] = 32'h1234_5678;
    apply(); #1;
    check_outputs("t1.own");
    chk("t1.grant", 64'(m_grant_o), 64'b0001);
    chk("t1.s_stb", 64'(s_stb_o), 64'b0010);
    chk("t1.ack", 64'(m_ack_o), 64'b0001);
    chk("t1.s_tag", 64'(s_tag_o), 64'd5);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; sack[1] = 1'b0;
    apply(); #1;
    check_outputs("t1.rel");
    tick();
    check_outputs("t1.idle");
    chk("t1.idle_grant", 64'(m_grant_o), 64'd0);
    tick();

    // Three simultaneous requesters, one transfer each.
    clear_all(); apply();
    do_reset();
    adr[0] = 32'h0000_0010; adr[1] = 32'h2000_0040; adr[2] = 32'h3000_0008;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b1; stb[i] = 1'b1; dat[i] = $urandom; start[i] = -1;
    end
    for (int j = 0; j < S; j++) begin
      sack[j] = 1'b1; sdat[j] = $urandom;
    end
    for (int c = 0; c < 20; c++) begin
      apply(); #1;
      check_outputs($sformatf("t2.c%0d", c));
      if (c == 4) chk("t2.overlap", 64'(s_stb_o), 64'b0100);
      if (mown >= 0 && mown < 3 && start[mown] < 0) start[mown] = c;
      prev = mown;
      tick();
      if (prev >= 0 && stb[prev]) begin
        cyc[prev] = 1'b0; stb[prev] = 1'b0;
      end
    end
    chk("t2.first0", 64'(start[0]), 64'd1);
    chk("t2.first1", 64'(start[1]), 64'd4);
    chk("t2.first2", 64'(start[2]), 64'd7);

    // Locked burst by master 1 while master 0 waits.
    clear_all();
    for (int j = 0; j < S; j++) begin
      sack[j] = 1'b1; sdat[j] = $urandom;
    end
    adr[1] = 32'h1000_0000; cyc[1] = 1'b1; stb[1] = 1'b1;
    apply(); #1;
    check_outputs("t3.req");
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_0100;
    for (int b = 0; b < 4; b++) begin
      adr[1] = 32'h1000_0000 + 32'(b * 4);
      apply(); #1;
      check_outputs($sformatf("t3.b%0d", b));
      chk("t3.hold", 64'(m_grant_o), 64'b0010);
      chk("t3.beat_ack", 64'(m_ack_o), 64'b0010);
      tick();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    apply(); #1;
    check_outputs("t3.drop");
    chk("t3.drop_grant", 64'(m_grant_o), 64'b0010);
    tick();
    check_outputs("t3.gap");
    chk("t3.gap_grant", 64'(m_grant_o), 64'd0);
    tick();
    check_outputs("t3.m0");
    chk("t3.m0_grant", 64'(m_grant_o), 64'b0001);
    chk("t3.m0_ack", 64'(m_ack_o), 64'b0001);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    apply();
    tick(); tick();

    // Unmapped address from master 2.
    clear_all();
    adr[2] = 32'hF000_0000; cyc[2] = 1'b1;
    apply(); #1;
    check_outputs("t4.req");
    tick();
    stb[2] = 1'b1;
    apply(); #1;
    check_outputs("t4.stb");
    chk("t4.no_stb", 64'(s_stb_o), 64'd0);
    chk("t4.no_cyc", 64'(s_cyc_o), 64'd0);
    chk("t4.err_now", 64'(m_err_o), 64'd0);
    tick();
    stb[2] = 1'b0;
    apply(); #1;
    check_outputs("t4.pulse");
    chk("t4.err_next", 64'(m_err_o), 64'b0100);
    tick();
    check_outputs("t4.after");
    chk("t4.err_once", 64'(m_err_o), 64'd0);
    tick();
    stb[2] = 1'b1;
    apply();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_outputs($sformatf("t4.h%0d", k));
      chk("t4.held_err", 64'(m_err_o), (k % 2 == 1) ? 64'b0100 : 64'd0);
      tick();
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    apply();
    tick(); tick();

    // Watchdog: slave 0 never answers master 3.
    clear_all();
    adr[3] = 32'h0000_0020; cyc[3] = 1'b1;
    apply(); #1;
    check_outputs("t5.req");
    tick();
    stb[3] = 1'b1;
    apply();
    for (int w = 1; w <= 10; w++) begin
      #1;
      check_outputs($sformatf("t5.w%0d", w));
      chk("t5.err", 64'(m_err_o), (w == 8) ? 64'b1000 : 64'd0);
      chk("t5.stb", 64'(s_stb_o), (w == 8) ? 64'd0 : 64'b0001);
      tick();
    end
    cyc[3] = 1'b0; stb[3] = 1'b0;
    apply();
    tick(); tick();

    // Reset in the middle of a burst.
    clear_all();
    for (int j = 0; j < S; j++) sack[j] = 1'b1;
    adr[0] = 32'h1000_0010; cyc[0] = 1'b1; stb[0] = 1'b1;
    apply(); #1;
    check_outputs("t6.req");
    tick();
    check_outputs("t6.beat");
    chk("t6.ack", 64'(m_ack_o), 64'b0001);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6.grant_drop", 64'(m_grant_o), 64'd0);
    chk("t6.cyc_drop", 64'(s_cyc_o), 64'd0);
    chk("t6.ack_drop", 64'(m_ack_o), 64'd0);
    chk("t6.stb_drop", 64'(s_stb_o), 64'd0);
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0000_0000;
    apply();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("t6.rel");
    tick();
    check_outputs("t6.first");
    chk("t6.m0_first", 64'(m_grant_o), 64'b0001);
    clear_all();
    apply();
    tick(); tick(); tick();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(0, 7) == 0) cyc[i] = !cyc[i];
        stb[i] = cyc[i] && ($urandom_range(0, 3) != 0);
        nib = 4'($urandom_range(0, 5));
        adr[i] = {nib, 28'($urandom)};
        dat[i] = $urandom;
        sel[i] = 4'($urandom);
        tag[i] = 3'($urandom);
        we[i] = 1'($urandom);
      end
      for (int j = 0; j < S; j++) begin
        sack[j] = (c >= 200) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
        serr[j] = ($urandom_range(0, 7) == 0);
        srty[j] = ($urandom_range(0, 7) == 0);
        sdat[j] = $urandom;
      end
      apply(); #1;
      check_outputs("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
